// File: rtl/scene_state_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : scene_state_buffer                                           |
// | Description : Double-buffered Camera/Light/Shape store. The decoder writes |
// |               the back bank and the renderer reads the front bank. Banks   |
// |               swap on opFrame once the renderer is idle. The optional      |
// |               SCENE_BANK_COPY_EN macro reloads the new back bank from the  |
// |               new front bank on every swap.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package scene_pkg;
  localparam int DECODED_INSTRUCTION_WIDTH = 44;
  localparam int CAMERA_WIDTH              = 176;
  localparam int LIGHT_WIDTH               = 130;
  localparam int SHAPE_WIDTH               = 182;

  typedef enum logic [3:0] {
    opUnsupported = 4'd0,
    opCameraSet   = 4'd1,
    opLightSet    = 4'd2,
    opShapeSet    = 4'd3,
    opShapeInit   = 4'd4,
    opShapeData   = 4'd5,
    opRender      = 4'd6,
    opFrame       = 4'd7,
    opLoop        = 4'd8,
    opEnd         = 4'd9
  } itype_e;

  typedef struct packed {
    logic [3:0]  iType;
    logic [7:0]  lIndex;
    logic [7:0]  sIndex;
    logic [3:0]  sType;
    logic [3:0]  prop;
    logic [15:0] data;
  } decoded_inst_t;
endpackage

module scene_state_buffer
  import scene_pkg::*;
#(
  parameter int NUM_SHAPES_P = 4,
  parameter int NUM_LIGHTS_P = 2,
  parameter int SHAPE_AW     = $clog2(NUM_SHAPES_P),
  parameter int LIGHT_AW     = $clog2(NUM_LIGHTS_P)
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 inst_valid,
  output logic                                 inst_ready,
  input  logic [DECODED_INSTRUCTION_WIDTH-1:0] inst,
  input  logic                                 render_busy,
  output logic                                 render_start,
  output logic                                 frame_swapped,
  output logic                                 program_done,
  output logic [7:0]                           err_count,
  output logic [CAMERA_WIDTH-1:0]              camera,
  input  logic                                 shape_rd_en,
  input  logic [SHAPE_AW-1:0]                  shape_rd_addr,
  output logic [SHAPE_WIDTH-1:0]               shape_rd_data,
  input  logic                                 light_rd_en,
  input  logic [LIGHT_AW-1:0]                  light_rd_addr,
  output logic [LIGHT_WIDTH-1:0]               light_rd_data
);

  // Each entry is an array of 16-bit fields indexed directly by prop; field 0 is unused.
  localparam int CAM_F   = 12;
  localparam int LIGHT_F = 10;
  localparam int SHAPE_F = 14;

  localparam logic [7:0]        NUM_SHAPES_C = 8'(NUM_SHAPES_P);
  localparam logic [7:0]        NUM_LIGHTS_C = 8'(NUM_LIGHTS_P);
  localparam logic [SHAPE_AW:0] SHAPE_LIM    = (SHAPE_AW+1)'(NUM_SHAPES_P);
  localparam logic [LIGHT_AW:0] LIGHT_LIM    = (LIGHT_AW+1)'(NUM_LIGHTS_P);

  typedef enum logic [0:0] {ST_ACCEPT = 1'b0, ST_SWAP_WAIT = 1'b1} state_e;

  state_e state_q, state_d;
  logic   bank_sel_q;
  logic   render_start_q, frame_swapped_q, program_done_q;
  logic [7:0] err_count_q;
  logic [SHAPE_WIDTH-1:0] shape_rd_q;
  logic [LIGHT_WIDTH-1:0] light_rd_q;

  logic [1:0][CAM_F-1:0][15:0]                     cam_q;
  logic [1:0][NUM_LIGHTS_P-1:0][LIGHT_F-1:0][15:0] light_q;
  logic [1:0][NUM_SHAPES_P-1:0][SHAPE_F-1:0][15:0] shape_q;

  decoded_inst_t in_s;
  logic back, accept, swap, drop, cam_we, light_we, shape_we, shape_init;
  logic [15:0] light_wdata, shape_wdata;
  logic [LIGHT_AW-1:0] lidx;
  logic [SHAPE_AW-1:0] sidx;
  logic [SHAPE_WIDTH-1:0] shape_front;
  logic [LIGHT_WIDTH-1:0] light_front;

  assign in_s = decoded_inst_t'(inst);
  assign back = ~bank_sel_q;
  assign lidx = in_s.lIndex[LIGHT_AW-1:0];
  assign sidx = in_s.sIndex[SHAPE_AW-1:0];

  always_comb begin
    state_d     = state_q;
    inst_ready  = (state_q == ST_ACCEPT);
    accept      = inst_valid && inst_ready;
    swap        = 1'b0;
    drop        = 1'b0;
    cam_we      = 1'b0;
    light_we    = 1'b0;
    shape_we    = 1'b0;
    shape_init  = 1'b0;
    light_wdata = (in_s.prop == 4'd1) ? {14'h0, in_s.data[1:0]} : in_s.data;
    shape_wdata = (in_s.prop == 4'd1) ? {12'h0, in_s.data[3:0]} :
                  (in_s.prop == 4'd2) ? {14'h0, in_s.data[1:0]} : in_s.data;
    case (state_q)
      ST_ACCEPT: begin
        if (accept && in_s.iType == opFrame) begin
          if (render_busy) state_d = ST_SWAP_WAIT;
          else             swap    = 1'b1;
        end
      end
      ST_SWAP_WAIT: begin
        if (!render_busy) begin
          swap    = 1'b1;
          state_d = ST_ACCEPT;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
    if (accept) begin
      case (in_s.iType)
        opCameraSet: begin
          if (in_s.prop != 4'd0 && in_s.prop <= 4'd11) cam_we = 1'b1;
          else                                         drop   = 1'b1;
        end
        opLightSet: begin
          if (in_s.lIndex < NUM_LIGHTS_C && in_s.prop != 4'd0 && in_s.prop <= 4'd9)
            light_we = 1'b1;
          else
            drop = 1'b1;
        end
        opShapeSet: begin
          if (in_s.sIndex < NUM_SHAPES_C && in_s.prop != 4'd0 && in_s.prop <= 4'd13)
            shape_we = 1'b1;
          else
            drop = 1'b1;
        end
        opShapeInit: begin
          if (in_s.sIndex < NUM_SHAPES_C) shape_init = 1'b1;
          else                            drop       = 1'b1;
        end
        opShapeData, opRender, opFrame, opLoop, opEnd: ;
        default: drop = 1'b1;
      endcase
    end
  end

  // Front-bank views: camera is combinational, shape/light feed the read registers.
  assign shape_front[3:0]  = shape_q[bank_sel_q][shape_rd_addr][1][3:0];
  assign shape_front[5:4]  = shape_q[bank_sel_q][shape_rd_addr][2][1:0];
  assign shape_front[21:6] = shape_q[bank_sel_q][shape_rd_addr][3];
  assign light_front[1:0]  = light_q[bank_sel_q][light_rd_addr][1][1:0];
  assign light_front[17:2] = light_q[bank_sel_q][light_rd_addr][2];

  for (genvar k = 1; k < CAM_F; k++) begin : g_cam
    assign camera[16*(k-1) +: 16] = cam_q[bank_sel_q][k];
  end
  for (genvar k = 4; k < SHAPE_F; k++) begin : g_shape
    assign shape_front[22+16*(k-4) +: 16] = shape_q[bank_sel_q][shape_rd_addr][k];
  end
  for (genvar k = 3; k < LIGHT_F; k++) begin : g_light
    assign light_front[18+16*(k-3) +: 16] = light_q[bank_sel_q][light_rd_addr][k];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= ST_ACCEPT;
      bank_sel_q      <= 1'b0;
      render_start_q  <= 1'b0;
      frame_swapped_q <= 1'b0;
      program_done_q  <= 1'b0;
      err_count_q     <= 8'h00;
      shape_rd_q      <= '0;
      light_rd_q      <= '0;
      cam_q           <= '0;
      light_q         <= '0;
      shape_q         <= '0;
    end else begin
      state_q         <= state_d;
      render_start_q  <= accept && (in_s.iType == opRender);
      frame_swapped_q <= swap;
      if (accept && in_s.iType == opEnd) program_done_q <= 1'b1;
      if (drop && err_count_q != 8'hFF)  err_count_q    <= err_count_q + 8'd1;
      if (swap)     bank_sel_q <= ~bank_sel_q;
      if (cam_we)   cam_q[back][in_s.prop] <= in_s.data;
      if (light_we) light_q[back][lidx][in_s.prop] <= light_wdata;
      if (shape_we) shape_q[back][sidx][in_s.prop] <= shape_wdata;
      if (shape_init)
        shape_q[back][sidx] <= {{(SHAPE_F-2){16'h0000}}, {12'h000, in_s.sType}, 16'h0000};
`ifdef SCENE_BANK_COPY_EN
      // Swaps never coincide with a bank write, so the copy has the bank to itself.
      if (swap) begin
        cam_q[bank_sel_q]   <= cam_q[back];
        light_q[bank_sel_q] <= light_q[back];
        shape_q[bank_sel_q] <= shape_q[back];
      end
`else
`endif
      if (shape_rd_en) shape_rd_q <= ({1'b0, shape_rd_addr} < SHAPE_LIM) ? shape_front : '0;
      if (light_rd_en) light_rd_q <= ({1'b0, light_rd_addr} < LIGHT_LIM) ? light_front : '0;
    end
  end

  assign render_start  = render_start_q;
  assign frame_swapped = frame_swapped_q;
  assign program_done  = program_done_q;
  assign err_count     = err_count_q;
  assign shape_rd_data = shape_rd_q;
  assign light_rd_data = light_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_scene_state_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_scene_state_buffer                                        |
// | Description : Directed and random stimulus for scene_state_buffer against  |
// |               a bank-level reference model.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_scene_state_buffer;
  import scene_pkg::*;

  localparam int NS = 3;
  localparam int NL = 3;

  logic clk_in = 1'b0;
  logic rst_in, inst_valid, inst_ready, render_busy;
  logic [DECODED_INSTRUCTION_WIDTH-1:0] inst;
  logic render_start, frame_swapped, program_done;
  logic [7:0] err_count;
  logic [CAMERA_WIDTH-1:0] camera;
  logic shape_rd_en, light_rd_en;
  logic [1:0] shape_rd_addr, light_rd_addr;
  logic [SHAPE_WIDTH-1:0] shape_rd_data;
  logic [LIGHT_WIDTH-1:0] light_rd_data;

  always #5 clk_in = ~clk_in;

  scene_state_buffer #(.NUM_SHAPES_P(NS), .NUM_LIGHTS_P(NL)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .render_busy(render_busy), .render_start(render_start),
    .frame_swapped(frame_swapped), .program_done(program_done), .err_count(err_count),
    .camera(camera), .shape_rd_en(shape_rd_en), .shape_rd_addr(shape_rd_addr),
    .shape_rd_data(shape_rd_data), .light_rd_en(light_rd_en),
    .light_rd_addr(light_rd_addr), .light_rd_data(light_rd_data)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: two banks of property tables plus the bank pointer.
  logic [15:0] m_cam   [2][12];
  logic [15:0] m_light [2][NL][10];
  logic [15:0] m_shape [2][NS][14];
  int  m_sel, m_err;
  bit  m_wait, m_done;
  logic [SHAPE_WIDTH-1:0] exp_srd;
  logic [LIGHT_WIDTH-1:0] exp_lrd;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CAMERA_WIDTH-1:0] exp_camera();
    logic [CAMERA_WIDTH-1:0] v = '0;
    for (int k = 1; k <= 11; k++) v[16*(k-1) +: 16] = m_cam[m_sel][k];
    return v;
  endfunction

  function automatic logic [SHAPE_WIDTH-1:0] exp_shape(input int s);
    logic [SHAPE_WIDTH-1:0] v = '0;
    if (s >= NS) return v;
    v[3:0]  = m_shape[m_sel][s][1][3:0];
    v[5:4]  = m_shape[m_sel][s][2][1:0];
    v[21:6] = m_shape[m_sel][s][3];
    for (int k = 4; k <= 13; k++) v[22+16*(k-4) +: 16] = m_shape[m_sel][s][k];
    return v;
  endfunction

  function automatic logic [LIGHT_WIDTH-1:0] exp_light(input int l);
    logic [LIGHT_WIDTH-1:0] v = '0;
    if (l >= NL) return v;
    v[1:0]  = m_light[m_sel][l][1][1:0];
    v[17:2] = m_light[m_sel][l][2];
    for (int k = 3; k <= 9; k++) v[18+16*(k-3) +: 16] = m_light[m_sel][l][k];
    return v;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < 2; b++) begin
      for (int f = 0; f < 12; f++) m_cam[b][f] = '0;
      for (int e = 0; e < NL; e++) for (int f = 0; f < 10; f++) m_light[b][e][f] = '0;
      for (int e = 0; e < NS; e++) for (int f = 0; f < 14; f++) m_shape[b][e][f] = '0;
    end
    m_sel = 0; m_err = 0; m_wait = 0; m_done = 0; exp_srd = '0; exp_lrd = '0;
  endtask

  task automatic model_apply(input logic [3:0] op, input int l, input int s,
                             input logic [3:0] st, input int p, input logic [15:0] d);
    int bk;
    bit bad;
    bk  = 1 - m_sel;
    bad = 0;
    case (op)
      opCameraSet: if (p >= 1 && p <= 11) m_cam[bk][p] = d; else bad = 1;
      opLightSet:  if (l < NL && p >= 1 && p <= 9) m_light[bk][l][p] = (p == 1) ? (d & 16'h3) : d;
                   else bad = 1;
      opShapeSet:  if (s < NS && p >= 1 && p <= 13)
                     m_shape[bk][s][p] = (p == 1) ? (d & 16'hF) : (p == 2) ? (d & 16'h3) : d;
                   else bad = 1;
      opShapeInit: if (s < NS) for (int f = 0; f < 14; f++) m_shape[bk][s][f] = (f == 1) ? {12'h0, st} : 16'h0;
                   else bad = 1;
      opShapeData, opRender, opFrame, opLoop: ;
      opEnd:       m_done = 1;
      default:     bad = 1;
    endcase
    if (bad && m_err < 255) m_err++;
  endtask

  task automatic model_swap();
`ifdef SCENE_BANK_COPY_EN
    for (int f = 0; f < 12; f++) m_cam[m_sel][f] = m_cam[1-m_sel][f];
    for (int e = 0; e < NL; e++) for (int f = 0; f < 10; f++) m_light[m_sel][e][f] = m_light[1-m_sel][e][f];
    for (int e = 0; e < NS; e++) for (int f = 0; f < 14; f++) m_shape[m_sel][e][f] = m_shape[1-m_sel][e][f];
`endif
    m_sel = 1 - m_sel;
  endtask

  task automatic check_outputs(input bit sw, input bit rs);
    chk("inst_ready", inst_ready, !m_wait);
    chk("frame_swapped", frame_swapped, sw);
    chk("render_start", render_start, rs);
    chk("err_count", err_count, m_err);
    chk("program_done", program_done, m_done);
    chk("camera", camera, exp_camera());
    chk("shape_rd_data", shape_rd_data, exp_srd);
    chk("light_rd_data", light_rd_data, exp_lrd);
  endtask

  task automatic cycle(input bit v, input logic [3:0] op, input int l, input int s,
                       input logic [3:0] st, input int p, input logic [15:0] d);
    bit acc, sw, rs;
    acc = v && !m_wait;
    sw  = (acc && op == opFrame && !render_busy) || (m_wait && !render_busy);
    rs  = acc && op == opRender;
    inst_valid = v;
    inst = {op, 8'(l), 8'(s), st, 4'(p), d};
    if (shape_rd_en) exp_srd = exp_shape(int'(shape_rd_addr));
    if (light_rd_en) exp_lrd = exp_light(int'(light_rd_addr));
    @(posedge clk_in); #1;
    inst_valid = 1'b0;
    if (acc) model_apply(op, l, s, st, p, d);
    if (sw) begin
      model_swap();
      m_wait = 0;
    end else if (acc && op == opFrame) begin
      m_wait = 1;
    end
    check_outputs(sw, rs);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, opUnsupported, 0, 0, 4'd0, 0, 16'h0);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    inst_valid = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    model_clear();
    check_outputs(0, 0);
  endtask

  initial begin
    int n;
    logic [3:0] op;
    rst_in = 1'b1; inst_valid = 1'b0; inst = '0; render_busy = 1'b0;
    shape_rd_en = 1'b0; shape_rd_addr = '0; light_rd_en = 1'b0; light_rd_addr = '0;
    model_clear();
    do_reset();
    do_reset();

    // Shape write lands in the back bank; a read during the swap cycle sees the old front.
    cycle(1, opShapeSet, 0, 1, 4'd0, 4, 16'h3C00);
    shape_rd_en = 1'b1; shape_rd_addr = 2'd1;
    cycle(1, opFrame, 0, 0, 4'd0, 0, 16'h0);
    chk("read_in_swap_cycle", shape_rd_data[37:22], 16'h0000);
    cycle(0, opUnsupported, 0, 0, 4'd0, 0, 16'h0);
    chk("shape1_xloc", shape_rd_data[37:22], 16'h3C00);
    shape_rd_en = 1'b0;
    idle(2);

    // Swap deferred while the renderer is busy; held-valid instructions are not taken.
    render_busy = 1'b1;
    cycle(1, opFrame, 0, 0, 4'd0, 0, 16'h0);
    repeat (5) cycle(1, opCameraSet, 0, 0, 4'd0, 1, 16'hBEEF);
    render_busy = 1'b0;
    cycle(0, opUnsupported, 0, 0, 4'd0, 0, 16'h0);
    chk("deferred_swap_pulse", frame_swapped, 1'b1);
    idle(2);

    // Dropped and no-op instructions.
    cycle(1, opLightSet, NL, 0, 4'd0, 3, 16'h1234);
    chk("err_after_bad_light", err_count, 8'd1);
    light_rd_en = 1'b1;
    for (int l = 0; l < 4; l++) begin
      light_rd_addr = 2'(l);
      idle(1);
    end
    light_rd_en = 1'b0;
    cycle(1, opLoop, 0, 0, 4'd0, 0, 16'h0);
    cycle(1, opShapeData, 0, 0, 4'd0, 0, 16'h0);
    cycle(1, opRender, 0, 0, 4'd0, 0, 16'h0);
    cycle(1, opEnd, 0, 0, 4'd0, 0, 16'h0);
    idle(2);
    for (int i = 0; i < 260; i++) cycle(1, (i % 6 == 0) ? 4'd0 : 4'(10 + i % 6), 0, 0, 4'd0, 0, 16'h0);
    chk("err_saturated", err_count, 8'd255);

    // Shape init wipes a populated entry.
    for (int p = 1; p <= 13; p++) cycle(1, opShapeSet, 0, 0, 4'd0, p, 16'(p * 16'h1111));
    cycle(1, opShapeInit, 0, 0, 4'd1, 0, 16'h0);
    cycle(1, opFrame, 0, 0, 4'd0, 0, 16'h0);
    shape_rd_en = 1'b1; shape_rd_addr = 2'd0;
    idle(1);
    chk("shape0_after_init", shape_rd_data, SHAPE_WIDTH'(1));
    shape_rd_en = 1'b0;

    // Incremental edits across two frames.
    cycle(1, opCameraSet, 0, 0, 4'd0, 1, 16'h4000);
    cycle(1, opFrame, 0, 0, 4'd0, 0, 16'h0);
    cycle(1, opCameraSet, 0, 0, 4'd0, 2, 16'h4200);
    cycle(1, opFrame, 0, 0, 4'd0, 0, 16'h0);
    chk("camera_yloc", camera[31:16], 16'h4200);
`ifdef SCENE_BANK_COPY_EN
    chk("camera_xloc_copied", camera[15:0], 16'h4000);
`else
    chk("camera_xloc_stale", camera[15:0], 16'h0000);
`endif

    // Random instruction mix with reads every cycle.
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) op = 4'($urandom_range(1, 4));
      shape_rd_en = 1'($urandom_range(0, 1)); shape_rd_addr = 2'($urandom_range(0, 3));
      light_rd_en = 1'($urandom_range(0, 1)); light_rd_addr = 2'($urandom_range(0, 3));
      render_busy = (op == opFrame) ? 1'($urandom_range(0, 1)) : 1'b0;
      cycle(1, op, $urandom_range(0, 3), $urandom_range(0, 3), 4'($urandom_range(0, 15)),
            $urandom_range(0, 15), 16'($urandom));
      if (m_wait) begin
        n = $urandom_range(1, 4);
        repeat (n) cycle(1, opCameraSet, 0, 0, 4'd0, 1, 16'($urandom));
        render_busy = 1'b0;
        idle(1);
      end
    end
    shape_rd_en = 1'b0; light_rd_en = 1'b0;

    // Reset while a swap is pending abandons it.
    cycle(1, opCameraSet, 0, 0, 4'd0, 3, 16'h7777);
    cycle(1, opFrame, 0, 0, 4'd0, 0, 16'h0);
    render_busy = 1'b1;
    cycle(1, opFrame, 0, 0, 4'd0, 0, 16'h0);
    idle(2);
    do_reset();
    chk("abort_ready", inst_ready, 1'b1);
    chk("abort_camera", camera, '0);
    render_busy = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
